// File: rtl/lut_rev_pkg.sv
// Shared types and default sizes for the LUT reverse-search block.
package lut_rev_pkg;

    localparam int unsigned DEF_SEL_W = 5;
    localparam int unsigned DEF_VAL_W = 47;

    typedef enum logic [2:0] {
        StIdle,
        StProbe0,
        StSearch,
        StNearest,
        StDone
    } state_e;

endpackage

// File: rtl/lut_rev_cmp.sv
// Combinational comparisons of the LUT entry against the query.
// With LUT_REV_NEAREST_EN defined, it also reports whether the upper neighbour
// is strictly closer to the query than the latched floor entry.
module lut_rev_cmp
    import lut_rev_pkg::*;
#(
    parameter int unsigned VAL_W = DEF_VAL_W
) (
    input  logic [VAL_W-1:0] lut_val,
    input  logic [VAL_W-1:0] query,
    output logic             le,
    output logic             eq
`ifdef LUT_REV_NEAREST_EN
    ,
    input  logic [VAL_W-1:0] floor_val,
    output logic             up_closer
`endif
);

    assign le = (lut_val <= query);
    assign eq = (lut_val == query);

`ifdef LUT_REV_NEAREST_EN
    logic [VAL_W-1:0] dist_up;
    logic [VAL_W-1:0] dist_dn;

    // This result is only meaningful when floor_val <= query < lut_val.
    // The top module qualifies it accordingly.
    assign dist_up   = lut_val - query;
    assign dist_dn   = query - floor_val;
    assign up_closer = (dist_up < dist_dn);
`endif

endmodule

// File: rtl/lut_reverse_search.sv
// Inverse lookup for a non-decreasing LUT. It returns the largest index whose
// entry is <= the query. The search is binary, one bit per cycle, and drives
// the table's sel input. The table answers combinationally on lut_val.
// With LUT_REV_NEAREST_EN defined, an extra NEAREST step may round up to
// idx+1 when that entry is strictly closer to the query.
module lut_reverse_search
    import lut_rev_pkg::*;
#(
    parameter int unsigned SEL_W = DEF_SEL_W,
    parameter int unsigned VAL_W = DEF_VAL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VAL_W-1:0] req_val,
    output logic [SEL_W-1:0] lut_sel,
    input  logic [VAL_W-1:0] lut_val,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SEL_W-1:0] rsp_idx,
    output logic             rsp_exact,
    output logic             rsp_under
);

    localparam logic [SEL_W-1:0] TOP_BIT = SEL_W'(1) << (SEL_W - 1);

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [SEL_W-1:0] lut_sel_q, lut_sel_d;
    logic [SEL_W-1:0] bit_q, bit_d;        // one-hot: index bit under test
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             under_q, under_d;
    logic [VAL_W-1:0] query_q, query_d;
    logic [SEL_W-1:0] new_idx;
    logic             le;
    logic             eq;
`ifdef LUT_REV_NEAREST_EN
    logic [VAL_W-1:0] floor_q, floor_d;    // entry[idx], tracked during SEARCH
    logic             up_closer;
`endif

    lut_rev_cmp #(
        .VAL_W (VAL_W)
    ) u_cmp (
        .lut_val   (lut_val),
        .query     (query_q),
        .le        (le),
        .eq        (eq)
`ifdef LUT_REV_NEAREST_EN
        ,
        .floor_val (floor_q),
        .up_closer (up_closer)
`endif
    );

    // Next-state logic for the FSM and the search datapath.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        lut_sel_d   = lut_sel_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        eq_d        = eq_q;
        under_d     = under_q;
        query_d     = query_q;
`ifdef LUT_REV_NEAREST_EN
        floor_d     = floor_q;
`endif
        // In SEARCH, lut_sel is the candidate idx|bit. Keep it if its entry fits.
        new_idx     = le ? lut_sel_q : idx_q;

        unique case (state_q)
            StIdle: begin
                if (!req_ready_q) begin
                    // First cycle out of reset. Raise ready, do not accept yet.
                    req_ready_d = 1'b1;
                end else if (req_valid) begin
                    query_d     = req_val;
                    req_ready_d = 1'b0;
                    lut_sel_d   = '0;
                    state_d     = StProbe0;
                end
            end
            StProbe0: begin
                under_d   = ~le;
                eq_d      = eq;
                idx_d     = '0;
                bit_d     = TOP_BIT;
                lut_sel_d = TOP_BIT;
`ifdef LUT_REV_NEAREST_EN
                floor_d   = lut_val;
`endif
                state_d   = StSearch;
            end
            StSearch: begin
                idx_d = new_idx;
                if (le) begin
                    eq_d = eq;
`ifdef LUT_REV_NEAREST_EN
                    floor_d = lut_val;
`endif
                end
                if (bit_q[0]) begin
`ifdef LUT_REV_NEAREST_EN
                    // Probe the upper neighbour. Saturate at the last index.
                    lut_sel_d = (&new_idx) ? new_idx : new_idx + SEL_W'(1);
                    state_d   = StNearest;
`else
                    state_d   = StDone;
`endif
                end else begin
                    bit_d     = bit_q >> 1;
                    lut_sel_d = new_idx | (bit_q >> 1);
                end
            end
`ifdef LUT_REV_NEAREST_EN
            StNearest: begin
                // A tie keeps the lower index, because up_closer is a strict compare.
                if (!eq_q && !under_q && !(&idx_q) && up_closer) begin
                    idx_d = idx_q + SEL_W'(1);
                end
                state_d = StDone;
            end
`endif
            StDone: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers. Reset aborts any search in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            lut_sel_q   <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            eq_q        <= 1'b0;
            under_q     <= 1'b0;
            query_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            lut_sel_q   <= lut_sel_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            eq_q        <= eq_d;
            under_q     <= under_d;
            query_q     <= query_d;
        end
    end

`ifdef LUT_REV_NEAREST_EN
    // Latched floor entry used by the nearest-rounding step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            floor_q <= '0;
        end else begin
            floor_q <= floor_d;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign lut_sel   = lut_sel_q;
    // An underflow overrides whatever the search path left in idx/eq.
    assign rsp_idx   = under_q ? '0 : idx_q;
    assign rsp_exact = eq_q & ~under_q;
    assign rsp_under = under_q;

endmodule

// File: tb/tb_lut_reverse_search.sv
// Self-checking bench for lut_reverse_search. The expected results come from a
// linear-scan reference model of floor (and optional nearest) lookup.
module tb_lut_reverse_search;

    localparam int SEL_W = 5;
    localparam int VAL_W = 47;
    localparam int N     = 32;
`ifdef LUT_REV_NEAREST_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             rsp_ready = 1'b0;
    logic [VAL_W-1:0] req_val = '0;
    logic             req_ready;
    logic [SEL_W-1:0] lut_sel;
    logic [VAL_W-1:0] lut_val;
    logic             rsp_valid;
    logic [SEL_W-1:0] rsp_idx;
    logic             rsp_exact;
    logic             rsp_under;

    logic [VAL_W-1:0] tbl [N];
    int checks = 0;
    int errors = 0;

    localparam logic [VAL_W-1:0] E0  = 47'h7ffff000027e;
    localparam logic [VAL_W-1:0] E1  = 47'h7ffff00ff681;
    localparam logic [VAL_W-1:0] E2  = 47'h7ffff01fd2b4;
    localparam logic [VAL_W-1:0] E31 = 47'h7ffff1c65743;

    assign lut_val = tbl[lut_sel];

    always #5 clk = ~clk;

    lut_reverse_search #(
        .SEL_W (SEL_W),
        .VAL_W (VAL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .lut_sel   (lut_sel),
        .lut_val   (lut_val),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_idx   (rsp_idx),
        .rsp_exact (rsp_exact),
        .rsp_under (rsp_under)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: scan for the largest index with entry <= q, then optionally round up.
    function automatic void ref_search(input logic [VAL_W-1:0] q, output logic [SEL_W-1:0] idx,
                                       output logic ex, output logic un);
        int fl = -1;
        logic [VAL_W-1:0] up;
        logic [VAL_W-1:0] dn;
        for (int i = 0; i < N; i++) if (tbl[i] <= q) fl = i;
        if (fl < 0) begin
            un = 1'b1; idx = '0; ex = 1'b0;
        end else begin
            un = 1'b0; idx = SEL_W'(fl); ex = (tbl[fl] == q);
`ifdef LUT_REV_NEAREST_EN
            if (!ex && fl < N - 1) begin
                up = tbl[fl+1] - q;
                dn = q - tbl[fl];
                if (up < dn) idx = SEL_W'(fl + 1);
            end
`endif
        end
    endfunction

    task automatic load_fixed_table();
        tbl[0] = E0;
        tbl[1] = E1;
        tbl[2] = E2;
        for (int i = 3; i < N - 1; i++) tbl[i] = E2 + VAL_W'((i - 2) * 32'h000f0000);
        tbl[N-1] = E31;
    endtask

    // Drives one query and returns the observations. lat = -1 means the query timed out.
    task automatic run_query(input logic [VAL_W-1:0] qv, output logic [SEL_W-1:0] idx,
                             output logic ex, output logic un, output int lat);
        int n = 0;
        lat = -1; idx = '0; ex = 1'b0; un = 1'b0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) return;
        req_valid = 1'b1;
        req_val   = qv;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_val   = VAL_W'({$urandom(), $urandom()});
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) return;
        lat = n; idx = rsp_idx; ex = rsp_exact; un = rsp_under;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #10;
        checks++;
        if ({req_ready, rsp_valid, lut_sel, rsp_idx, rsp_exact, rsp_under} !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b sel=%0d idx=%0d ex=%b un=%b, required all 0",
                     req_ready, rsp_valid, lut_sel, rsp_idx, rsp_exact, rsp_under);
        end
        @(negedge clk) reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_before_edge: got %b required 0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_edge: got %b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [SEL_W-1:0] idx;
        logic ex, un;
        int lat;
        load_fixed_table();

        run_query(E1, idx, ex, un, lat);
        checks++;
        if ({idx, ex, un} !== {5'd1, 1'b1, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL exact_e1: idx=%0d ex=%b un=%b lat=%0d, required 1 1 0 %0d",
                     idx, ex, un, lat, LAT);
        end

        run_query(47'h7ffff0000000, idx, ex, un, lat);
        checks++;
        if ({idx, ex, un} !== {5'd0, 1'b0, 1'b1} || lat !== LAT) begin
            errors++;
            $display("FAIL under: idx=%0d ex=%b un=%b lat=%0d, required 0 0 1 %0d",
                     idx, ex, un, lat, LAT);
        end

        run_query(47'h7fffffffffff, idx, ex, un, lat);
        checks++;
        if ({idx, ex, un} !== {5'd31, 1'b0, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL saturate: idx=%0d ex=%b un=%b lat=%0d, required 31 0 0 %0d",
                     idx, ex, un, lat, LAT);
        end

        run_query(47'h7ffff01fd000, idx, ex, un, lat);
        checks++;
`ifdef LUT_REV_NEAREST_EN
        if ({idx, ex, un} !== {5'd2, 1'b0, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL near_e2: idx=%0d ex=%b un=%b lat=%0d, required 2 0 0 %0d",
                     idx, ex, un, lat, LAT);
        end
`else
        if ({idx, ex, un} !== {5'd1, 1'b0, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL floor_e1: idx=%0d ex=%b un=%b lat=%0d, required 1 0 0 %0d",
                     idx, ex, un, lat, LAT);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n = 0;
        load_fixed_table();
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1;
        req_val   = E2;
        @(posedge clk); #1;
        req_val = 47'h0;  // changing the query after acceptance must have no effect
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== LAT) begin
            errors++; $display("FAIL bp_latency: got %0d required %0d", n, LAT);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req_val = VAL_W'({$urandom(), $urandom()});
            checks++;
            if ({rsp_valid, req_ready, rsp_idx, rsp_exact, rsp_under} !==
                {1'b1, 1'b0, 5'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b idx=%0d ex=%b un=%b, required 1 0 2 1 0",
                         i, rsp_valid, req_ready, rsp_idx, rsp_exact, rsp_under);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_search();
        logic [SEL_W-1:0] idx;
        logic ex, un;
        int lat;
        int n = 0;
        load_fixed_table();
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1;
        req_val   = E31;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, lut_sel, req_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_values: vld=%b sel=%0d rdy=%b, required 0 0 0",
                     rsp_valid, lut_sel, req_ready);
        end
        @(negedge clk) reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_ready_early: got %b required 0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_ready: rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
        end
        run_query(E31, idx, ex, un, lat);
        checks++;
        if ({idx, ex, un} !== {5'd31, 1'b1, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL midreset_next: idx=%0d ex=%b un=%b lat=%0d, required 31 1 0 %0d",
                     idx, ex, un, lat, LAT);
        end
    endtask

    task automatic test_tie();
        logic [SEL_W-1:0] idx;
        logic ex, un;
        int lat;
        tbl[0] = 47'h000100000000;
        tbl[1] = 47'h000100000200;
        for (int i = 2; i < N; i++) tbl[i] = tbl[1] + VAL_W'(i * 32'h1000);
        run_query(47'h000100000100, idx, ex, un, lat);
        checks++;
        if ({idx, ex, un} !== {5'd0, 1'b0, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL tie: idx=%0d ex=%b un=%b lat=%0d, required 0 0 0 %0d",
                     idx, ex, un, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [SEL_W-1:0] idx, eidx;
        logic ex, un, eex, eun;
        int lat;
        logic [63:0] acc;
        logic [63:0] step;
        logic [VAL_W-1:0] q;
        int k, mode, r;
        for (int t = 0; t < 20; t++) begin
            acc = (64'($urandom_range(0, 6)) << 44) | 64'($urandom());
            for (int i = 0; i < N; i++) begin
                if (i > 0) begin
                    r = $urandom_range(0, 3);
                    if (r == 0) step = 64'd0;
                    else if (r == 1) step = 64'($urandom_range(1, 8));
                    else step = (64'($urandom_range(0, 63)) << 32) | 64'($urandom());
                    acc = acc + step;
                end
                tbl[i] = acc[VAL_W-1:0];
            end
            for (int j = 0; j < 15; j++) begin
                k    = $urandom_range(0, N - 1);
                mode = $urandom_range(0, 5);
                case (mode)
                    0: q = tbl[k];
                    1: q = tbl[k] + VAL_W'(1);
                    2: q = tbl[k] - VAL_W'(1);
                    3: begin
                        step = 64'(tbl[N-1] - tbl[0]) + 64'd1;
                        acc  = {$urandom(), $urandom()} % step;
                        q    = tbl[0] + acc[VAL_W-1:0];
                    end
                    4: q = VAL_W'({$urandom(), $urandom()});
                    default: begin
                        if (k == N - 1) k = N - 2;
                        acc = (64'(tbl[k]) + 64'(tbl[k+1])) >> 1;
                        q   = acc[VAL_W-1:0];
                    end
                endcase
                ref_search(q, eidx, eex, eun);
                run_query(q, idx, ex, un, lat);
                checks++;
                if ({idx, ex, un} !== {eidx, eex, eun} || lat !== LAT) begin
                    errors++;
                    $display("FAIL random t%0d q=%h: idx=%0d ex=%b un=%b lat=%0d, required %0d %b %b %0d",
                             t, q, idx, ex, un, lat, eidx, eex, eun, LAT);
                end
            end
        end
    endtask

    initial begin
        load_fixed_table();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_search();
        test_tie();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
